// File: rtl/cache_rd_arbiter.sv
// Shares one single-beat AXI read port between icache and dcache refills, one transaction at a time.
// Build option CACHE_ARB_RR_EN: round-robin tie-break instead of fixed dcache priority.
module cache_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read_ena,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_read_resp,
    output logic [DATA_W-1:0] ic_data,
    output logic              ic_valid,
    output logic              arb_working_ti,
    input  logic              dc_read_ena,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_read_resp,
    output logic [DATA_W-1:0] dc_data,
    output logic              dc_valid,
    output logic              arb_working_td,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp
);
    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;
    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              aband_q, aband_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              grant_dc;
    logic              owner_ena;
    logic              owner_resp;

`ifdef CACHE_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the side that did not win last time gets the bus.
    assign grant_dc = dc_read_ena && (!ic_read_ena || last_q == OWN_IC);

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && (ic_read_ena || dc_read_ena))
            last_d = grant_dc ? OWN_DC : OWN_IC;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= OWN_IC;
        else      last_q <= last_d;
    end
`else
    assign grant_dc = dc_read_ena;
`endif

    assign owner_ena  = (owner_q == OWN_DC) ? dc_read_ena  : ic_read_ena;
    assign owner_resp = (owner_q == OWN_DC) ? dc_read_resp : ic_read_resp;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        aband_d = aband_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (ic_read_ena || dc_read_ena) begin
                    owner_d = grant_dc ? OWN_DC : OWN_IC;
                    addr_d  = grant_dc ? dc_addr : ic_addr;
                    aband_d = 1'b0;
                    state_d = AR;
                end
            end
            AR: begin
                // A requester that lets go mid-flight still lets the bus beat finish.
                aband_d = aband_q | ~owner_ena;
                if (ar_ready) state_d = R;
            end
            R: begin
                aband_d = aband_q | ~owner_ena;
                if (r_valid) begin
                    data_d  = (r_resp == 2'b00) ? r_data : '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (aband_q || owner_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IC;
            aband_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            aband_q <= aband_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign ar_valid       = (state_q == AR);
    assign ar_addr        = addr_q;
    assign r_ready        = (state_q == R);
    assign ic_data        = data_q;
    assign dc_data        = data_q;
    assign ic_valid       = (state_q == RESP) && (owner_q == OWN_IC) && !aband_q;
    assign dc_valid       = (state_q == RESP) && (owner_q == OWN_DC) && !aband_q;
    assign arb_working_ti = (state_q != IDLE) && (owner_q == OWN_DC);
    assign arb_working_td = (state_q != IDLE) && (owner_q == OWN_IC);
endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter: vector table of refill requests, AXI slave model, scoreboard of deliveries.
module tb_cache_rd_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ic_addr = '0, dc_addr = '0;
    logic          ic_read_resp = 1'b0, dc_read_resp = 1'b0;
    logic          ic_read_ena, dc_read_ena;
    logic [DW-1:0] ic_data, dc_data;
    logic          ic_valid, dc_valid, arb_working_ti, arb_working_td;
    logic          ar_valid, r_ready;
    logic          ar_ready = 1'b0, r_valid = 1'b0;
    logic [AW-1:0] ar_addr;
    logic [DW-1:0] r_data = '0;
    logic [1:0]    r_resp = 2'b00;

    int tests = 0;
    int fails = 0;

    // Request lines: host raises by bumping req_n, monitor retires by copying it to ack_n.
    int ic_req_n = 0, ic_ack_n = 0, dc_req_n = 0, dc_ack_n = 0;
    bit ic_drop = 1'b0, dc_drop = 1'b0;
    assign ic_read_ena = (ic_req_n != ic_ack_n) && !ic_drop;
    assign dc_read_ena = (dc_req_n != dc_ack_n) && !dc_drop;

    // AXI slave model knobs
    int            ar_dly = 0, r_dly = 0;
    logic [DW-1:0] rb_i = '0, rb_d = '0;
    logic [1:0]    rr_v = 2'b00;
    logic [AW-1:0] cur_ia = '0, a_cap = '0;
    int            addr_bad_n = 0;
    int            s_st = 0, s_cnt = 0;

    typedef struct {
        bit            dc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        bit            ic;
        bit            dc;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        int            ar_d;
        int            r_d;
        logic [DW-1:0] rbi;
        logic [DW-1:0] rbd;
        logic [1:0]    rr;
        bit            fx_dc;
        bit            rr_dc;
    } vec_t;
    vec_t vt[8];

    cache_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ic_read_ena(ic_read_ena), .ic_addr(ic_addr), .ic_read_resp(ic_read_resp),
        .ic_data(ic_data), .ic_valid(ic_valid), .arb_working_ti(arb_working_ti),
        .dc_read_ena(dc_read_ena), .dc_addr(dc_addr), .dc_read_resp(dc_read_resp),
        .dc_data(dc_data), .dc_valid(dc_valid), .arb_working_td(arb_working_td),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic push(input bit dc, input logic [AW-1:0] a, input logic [DW-1:0] rb);
        exp_t e;
        e.dc   = dc;
        e.addr = a;
        e.data = (rr_v != 2'b00) ? '0 : rb;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit ic, input bit dc, input logic [AW-1:0] ia, input logic [AW-1:0] da);
        if (ic) begin ic_addr = ia; cur_ia = ia; ic_drop = 1'b0; ic_req_n = ic_ack_n + 1; end
        if (dc) begin dc_addr = da; dc_drop = 1'b0; dc_req_n = dc_ack_n + 1; end
    endtask

    // Cycles from the driving negedge until the first valid; optionally checks ownership flags in AR.
    task automatic meas(output int lat, input int chg_at, input bit chk_w, input bit fd, input string nm);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1 && chk_w) begin
                chk({nm, "_working_ti"}, arb_working_ti, fd);
                chk({nm, "_working_td"}, arb_working_td, !fd);
            end
            if (c == chg_at) ic_addr = ~ic_addr;
            if (ic_valid || dc_valid) begin lat = c; break; end
        end
    endtask

    task automatic wait_done(input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ic_read_ena && !dc_read_ena) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s_timeout: %0d deliveries pending, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // AXI slave: ar_ready after ar_dly cycles, single r beat after r_dly more cycles.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            s_st = 0; ar_ready = 1'b0; r_valid = 1'b0;
        end else begin
            if (ar_ready) begin ar_ready = 1'b0; s_st = 2; s_cnt = r_dly; end
            if (r_valid)  begin r_valid = 1'b0; s_st = 0; end
            if (s_st == 0 && ar_valid) begin a_cap = ar_addr; s_cnt = ar_dly; s_st = 1; end
            if (s_st == 1) begin
                if (ar_addr != a_cap) addr_bad_n++;
                if (s_cnt == 0) ar_ready = 1'b1;
                else s_cnt--;
            end else if (s_st == 2 && !r_valid) begin
                if (s_cnt == 0) begin
                    r_valid = 1'b1;
                    r_data  = (a_cap == cur_ia) ? rb_i : rb_d;
                    r_resp  = rr_v;
                end else s_cnt--;
            end
        end
    end

    // Monitor: every delivered refill must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            ic_read_resp = 1'b0;
            dc_read_resp = 1'b0;
            if (rst && (ic_valid || dc_valid)) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_valid: ic_valid=%0b dc_valid=%0b, required no delivery", ic_valid, dc_valid);
                end else begin
                    e = exp_q.pop_front();
                    chk("owner_dc", dc_valid, e.dc);
                    chk("owner_ic", ic_valid, !e.dc);
                    chk("data", dc_valid ? dc_data : ic_data, e.data);
                    chk("ar_addr", a_cap, e.addr);
                end
                if (ic_valid) begin ic_read_resp = 1'b1; ic_ack_n = ic_req_n; end
                if (dc_valid) begin dc_read_resp = 1'b1; dc_ack_n = dc_req_n; end
            end
        end
    end

    initial begin
        vec_t v;
        bit   fd;
        bit   ok;
        int   lat;
        int   bad0;

        //        ic    dc    ia                    da            ar r  rbi                   rbd                    rr     fx    rr
        vt[0] = '{1'b1, 1'b0, 64'h8000_0000,       64'h0,        0, 0, 64'h1234,             64'h0,                 2'b00, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 64'h0,               64'h4000_0040, 0, 0, 64'h0,               64'hDEAD_BEEF_0000_0001, 2'b00, 1'b1, 1'b1};
        vt[2] = '{1'b1, 1'b1, 64'h1000,            64'h2000,     0, 0, 64'h11,               64'h22,                2'b00, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b0, 64'h3000,            64'h0,        5, 3, 64'h55,               64'h0,                 2'b10, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 64'h5000,            64'h6000,     1, 2, 64'h5151,             64'h6161,              2'b00, 1'b1, 1'b1};
        vt[5] = '{1'b0, 1'b1, 64'h0,               64'h7000,     2, 1, 64'h0,                64'h7777,              2'b01, 1'b1, 1'b1};
        vt[6] = '{1'b1, 1'b1, 64'hA000,            64'hB000,     0, 0, 64'hAAAA,             64'hBBBB,              2'b00, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,    0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,              2'b00, 1'b0, 1'b0};

        #1 rst = 1'b0;
        #3;
        chk("reset_ar_valid", ar_valid, 1'b0);
        chk("reset_r_ready", r_ready, 1'b0);
        chk("reset_valids", {ic_valid, dc_valid}, 2'b00);
        chk("reset_working", {arb_working_ti, arb_working_td}, 2'b00);
        chk("reset_ar_addr", ar_addr, 64'h0);
        chk("reset_data", {ic_data, dc_data}, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            v = vt[i];
            ar_dly = v.ar_d; r_dly = v.r_d; rb_i = v.rbi; rb_d = v.rbd; rr_v = v.rr;
`ifdef CACHE_ARB_RR_EN
            fd = v.rr_dc;
`else
            fd = v.fx_dc;
`endif
            if (!(v.ic && v.dc)) fd = v.dc;
            if (fd) begin
                push(1'b1, v.da, v.rbd);
                if (v.ic) push(1'b0, v.ia, v.rbi);
            end else begin
                push(1'b0, v.ia, v.rbi);
                if (v.dc) push(1'b1, v.da, v.rbd);
            end
            drive(v.ic, v.dc, v.ia, v.da);
            meas(lat, 0, 1'b1, fd, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_latency", i), lat, 3 + v.ar_d + v.r_d);
            wait_done($sformatf("vec%0d", i));
        end

        // Address must stay frozen through a long AR wait even if the requester changes it.
        ar_dly = 5; r_dly = 3; rr_v = 2'b00; rb_i = 64'hC0DE;
        bad0 = addr_bad_n;
        push(1'b0, 64'h8000_1000, 64'hC0DE);
        drive(1'b1, 1'b0, 64'h8000_1000, 64'h0);
        meas(lat, 2, 1'b1, 1'b0, "addr_hold");
        chk("addr_hold_latency", lat, 11);
        chk("addr_hold_stable", addr_bad_n, bad0);
        wait_done("addr_hold");

        // dcache abandons during AR; its beat completes silently, then the waiting icache is served.
        ar_dly = 3; r_dly = 0; rb_i = 64'h77; rb_d = 64'h99;
        drive(1'b0, 1'b1, 64'h0, 64'h3300);
        @(negedge clk);
        chk("drop_owner_dc", arb_working_ti, 1'b1);
        dc_drop = 1'b1;
        push(1'b0, 64'h3400, 64'h77);
        drive(1'b1, 1'b0, 64'h3400, 64'h0);
        wait_done("drop");

        // Reset while the read beat is outstanding.
        ar_dly = 0; r_dly = 10; rb_i = 64'hBAD;
        push(1'b0, 64'h8000_2000, 64'hBAD);
        drive(1'b1, 1'b0, 64'h8000_2000, 64'h0);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (r_ready) begin ok = 1'b1; break; end
        end
        chk("rst_reached_r", ok, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_r_ready", r_ready, 1'b0);
        chk("rst_mid_ar_valid", ar_valid, 1'b0);
        chk("rst_mid_valids", {ic_valid, dc_valid}, 2'b00);
        chk("rst_mid_working", {arb_working_ti, arb_working_td}, 2'b00);
        chk("rst_mid_ar_addr", ar_addr, 64'h0);
        chk("rst_mid_data", ic_data, 64'h0);
        exp_q.delete();
        ic_drop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        r_dly = 0; rb_i = 64'h600D;
        push(1'b0, 64'h8000_3000, 64'h600D);
        drive(1'b1, 1'b0, 64'h8000_3000, 64'h0);
        meas(lat, 0, 1'b1, 1'b0, "post_rst");
        chk("post_rst_latency", lat, 3);
        wait_done("post_rst");

        // First tie after reset: dcache wins in either build (last grant resets to icache).
        rb_i = 64'h1111; rb_d = 64'h2222;
        push(1'b1, 64'h9000, 64'h2222);
        push(1'b0, 64'h9100, 64'h1111);
        drive(1'b1, 1'b1, 64'h9100, 64'h9000);
        meas(lat, 0, 1'b1, 1'b1, "post_rst_tie");
        chk("post_rst_tie_latency", lat, 3);
        wait_done("post_rst_tie");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
